// File: rtl/ad7276_emu_pkg.sv
// Shared types and sizing helpers for the AD7276 responder.
package ad7276_emu_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_t;

  // Default geometry of an AD7276 frame.
  localparam int DEF_ADC_LENGTH  = 12;
  localparam int DEF_LEAD_ZEROS  = 2;
  localparam int DEF_TRAIL_ZEROS = 2;

  // Total bits clocked out per frame.
  function automatic int frame_bits(input int lead, input int adc, input int trail);
    return lead + adc + trail;
  endfunction

  // Width of a counter that can hold 0..fb inclusive.
  function automatic int cnt_width(input int fb);
    return $clog2(fb + 1);
  endfunction

endpackage

// File: rtl/ad7276_emulator_sync.sv
// Multi-flop synchronizer followed by a single-cycle edge detector.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain plus one delayed copy of the synced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pad};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/ad7276_emulator.sv
// AD7276 serial ADC responder: answers a cs/sclk master with
// {lead zeros, sample MSB-first, trail zeros} on sdata.
module ad7276_emulator
  import ad7276_emu_pkg::*;
#(
  parameter int ADC_LENGTH  = DEF_ADC_LENGTH,
  parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
  parameter int TRAIL_ZEROS = DEF_TRAIL_ZEROS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK100MHz,
  input  logic                  ARESET,
  input  logic                  cs,
  input  logic                  sclk,
  output logic                  sdata,
  output logic                  sdata_oe,
  input  logic [ADC_LENGTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  output logic                  abort
);

  localparam int FRAME_BITS = frame_bits(LEAD_ZEROS, ADC_LENGTH, TRAIL_ZEROS);
  localparam int CNT_W      = cnt_width(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  // Place a sample inside a frame word with its lead/trail zero padding.
  function automatic logic [FRAME_BITS-1:0] build_word(input logic [ADC_LENGTH-1:0] sample);
    return FRAME_BITS'(sample) << TRAIL_ZEROS;
  endfunction

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_BITS-2:0]   shreg;
  logic [ADC_LENGTH-1:0]   hold_data;
  logic                    hold_valid;
  logic [ADC_LENGTH-1:0]   last_sample;
  logic [FRAME_BITS-1:0]   load_word;

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic sclk_fall_act;
  logic frame_start;
  logic accept;
  logic unused_sclk;

  // cs idles high, so its synchronizer resets high to avoid a false edge out of reset.
  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_cs_sync (
    .clk   (CLK100MHz),
    .rst   (ARESET),
    .pad   (cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sclk_sync (
    .clk   (CLK100MHz),
    .rst   (ARESET),
    .pad   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Rising sclk and the raw sclk level carry no information for this responder.
  assign unused_sclk = sclk_level ^ sclk_rise;

  // sclk is only meaningful while cs is low; a cs rise in the same cycle wins.
  assign sclk_fall_act = sclk_fall & ~cs_level;
  assign frame_start   = (state == IDLE) && cs_fall;
  assign accept        = s_valid && s_ready;
  assign s_ready       = ~hold_valid;
  assign load_word     = build_word(hold_valid ? hold_data : last_sample);

  // One-deep sample buffer: filled by the handshake, emptied only by a frame start.
  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (accept) begin
        hold_data  <= s_data;
        hold_valid <= 1'b1;
      end else if (frame_start && hold_valid) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Frame sequencer with registered pad and status outputs.
  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      last_sample <= '0;
      sdata       <= 1'b0;
      sdata_oe    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      abort       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            sdata_oe <= 1'b1;
            cnt      <= '0;
            sdata    <= load_word[FRAME_BITS-1];
            shreg    <= load_word[FRAME_BITS-2:0];
            if (hold_valid) begin
              last_sample <= hold_data;
            end else begin
              underrun <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            abort    <= 1'b1;
            sdata_oe <= 1'b0;
            sdata    <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (sclk_fall_act) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              sdata_oe   <= 1'b0;
              sdata      <= 1'b0;
              frame_done <= 1'b1;
              state      <= QUIET;
            end else begin
              sdata <= shreg[FRAME_BITS-2];
              shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
            end
          end
        end
        QUIET: begin
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          sdata_oe <= 1'b0;
          sdata    <= 1'b0;
        end
      endcase
    end
  end

endmodule
